// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO with occupancy count, programmable threshold
// flags, sticky overflow/underflow errors and a synchronous flush.
module fifo_param_sync #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int AE_THRESH = 4,
    parameter int AF_THRESH = 28
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       write_i,
    input  logic                       read_i,
    input  logic [WIDTH-1:0]           data_in_i,
    output logic [WIDTH-1:0]           data_out_o,
    output logic                       f_full_o,
    output logic                       f_empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] usedw_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_OTHER = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    usedw_q, usedw_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             rd_acc, wr_acc, mem_we;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        usedw_d    = usedw_q;
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        mem_we     = 1'b0;
        rd_acc     = read_i && (state_q != ST_EMPTY);
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        wr_acc     = write_i && ((state_q != ST_FULL) || rd_acc);

        if (clear_i) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (read_i && !rd_acc)  unf_d = 1'b1;
            if (write_i && !wr_acc) ovf_d = 1'b1;
            if (rd_acc) begin
                data_out_d = mem_q[rd_ptr_q];
                rd_ptr_d   = ptr_inc(rd_ptr_q);
            end
            if (wr_acc) begin
                mem_we   = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            case ({wr_acc, rd_acc})
                2'b10:   usedw_d = usedw_q + CW'(1);
                2'b01:   usedw_d = usedw_q - CW'(1);
                default: usedw_d = usedw_q;
            endcase
            case (state_q)
                ST_EMPTY: if (wr_acc && !rd_acc) state_d = ST_OTHER;
                ST_OTHER: begin
                    if (rd_acc && !wr_acc && usedw_q == CW'(1))
                        state_d = ST_EMPTY;
                    else if (wr_acc && !rd_acc && usedw_q == CW'(DEPTH-1))
                        state_d = ST_FULL;
                end
                ST_FULL:  if (rd_acc && !wr_acc) state_d = ST_OTHER;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usedw_q    <= usedw_d;
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage needs no reset; contents are only observable after a write.
    always_ff @(posedge clock_i) begin
        if (!reset_i && mem_we) mem_q[wr_ptr_q] <= data_in_i;
    end

    assign data_out_o     = data_out_q;
    assign usedw_o        = usedw_q;
    assign f_empty_o      = (state_q == ST_EMPTY);
    assign f_full_o       = (state_q == ST_FULL);
    assign almost_empty_o = (usedw_q <= CW'(AE_THRESH));
    assign almost_full_o  = (usedw_q >= CW'(AF_THRESH));
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: doc/fifo_param_sync.md
Name: fifo_param_sync

Overview:
- Parametrised synchronous FIFO; next generation of the fixed 32x8 FIFO.
- Generalised to any WIDTH/DEPTH (DEPTH need not be a power of two).
- Adds programmable almost-full/almost-empty flags, a used-word count, sticky overflow/underflow errors and a synchronous flush.
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 32: number of storage words; legal range DEPTH >= 2.
- AE_THRESH, 4: ALMOST_EMPTY asserts when USEDW <= AE_THRESH.
- AF_THRESH, 28: ALMOST_FULL asserts when USEDW >= AF_THRESH; constraint AE_THRESH < AF_THRESH <= DEPTH.

Ports:
- CLOCK  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CLEAR  in  1  synchronous flush.
- WRITE  in  1  write request.
- READ  in  1  read request.
- DATA_IN  in  WIDTH  write data.
- DATA_OUT  out  WIDTH  registered read data.
- F_FULL  out  1  FIFO full.
- F_EMPTY  out  1  FIFO empty.
- ALMOST_FULL  out  1  threshold flag.
- ALMOST_EMPTY  out  1  threshold flag.
- USEDW  out  $clog2(DEPTH+1)  number of stored words, 0..DEPTH.
- OVERFLOW  out  1  sticky error: write was rejected.
- UNDERFLOW  out  1  sticky error: read was rejected.

Behaviour:
- One clock. Reset is synchronous and active-high. Priority order: RESET > CLEAR > READ/WRITE.
- Reset values:
  - Write/read pointers = 0, USEDW = 0, state = EMPTY.
  - F_EMPTY = 1, F_FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0.
  - DATA_OUT = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - Memory contents are don't-care.
- CLEAR: identical to reset, except DATA_OUT holds its current value.
- State machine: EMPTY, OTHER, FULL (2-bit register).
  - EMPTY -> OTHER: accepted write, no read.
  - OTHER -> EMPTY: USEDW == 1, accepted read, no write.
  - OTHER -> FULL: USEDW == DEPTH-1, accepted write, no read.
  - FULL -> OTHER: accepted read, no write.
  - Simultaneous accepted read and write: state unchanged.
- Accept rules:
  - Read is accepted when READ && state != EMPTY.
  - Write is accepted when WRITE && (state != FULL || read accepted in the same cycle).
- Write path:
  - Accepted write stores DATA_IN at mem[wr_ptr].
  - wr_ptr increments and wraps DEPTH-1 -> 0.
- Read path:
  - Accepted read loads DATA_OUT <= mem[rd_ptr] at the same edge, so data is visible 1 cycle after READ.
  - rd_ptr increments and wraps DEPTH-1 -> 0.
  - DATA_OUT holds between reads.
- Simultaneous read and write:
  - When FULL: both accepted; USEDW stays DEPTH.
  - When EMPTY: write accepted, read rejected (no fall-through); UNDERFLOW set.
- USEDW arithmetic: +1 on write-only, -1 on read-only, unchanged otherwise. It never leaves 0..DEPTH.
- Flags: combinational decode of the registered state/USEDW, so they are valid in the cycle after the causing edge.
  - F_EMPTY = (state == EMPTY).
  - F_FULL = (state == FULL).
  - ALMOST_EMPTY = (USEDW <= AE_THRESH).
  - ALMOST_FULL = (USEDW >= AF_THRESH).
- Overflow: WRITE while FULL with no accepted read.
  - Data is dropped; memory, pointers and USEDW are unchanged.
  - OVERFLOW is set and stays set until RESET or CLEAR.
- Underflow: READ while EMPTY.
  - Pointers unchanged; DATA_OUT holds.
  - UNDERFLOW is set and stays set until RESET or CLEAR.
- RESET or CLEAR asserted mid-stream: any READ/WRITE in that cycle is ignored; the FIFO restarts empty on the next cycle.

Test Plan:
- Reset, then write 0x33, wait 1 cycle -> F_EMPTY=0, state=OTHER, USEDW=1. Read -> DATA_OUT=0x33 one cycle later, F_EMPTY=1, USEDW=0.
- Write 0x00..0x1F (32 words) -> F_FULL=1 after the 32nd write, ALMOST_FULL=1 from USEDW=28. Read 32 words -> DATA_OUT sequence 0x00..0x1F in order, ALMOST_EMPTY=1 once USEDW<=4.
- From FULL, write 0xAA with no read -> OVERFLOW=1, USEDW=32, next 32 reads contain no 0xAA. From EMPTY, read -> UNDERFLOW=1, DATA_OUT unchanged.
- Simultaneous READ+WRITE in EMPTY, OTHER (USEDW=5) and FULL -> USEDW = 1 / 5 / 32 respectively, FIFO order preserved; UNDERFLOW=1 only in the EMPTY case.
- Wrap-around with DEPTH=5 instance: 3 cycles of write 3 / read 3 -> pointers wrap 4 -> 0, data order correct, USEDW=0 at the end.
- Fill with 10 words, assert CLEAR together with WRITE -> next cycle USEDW=0, F_EMPTY=1, OVERFLOW=0, DATA_OUT held. Repeat with RESET -> DATA_OUT=0.
